// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt priority arbiter.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam int DEF_PERIPHERALS = 16;
  localparam int DEF_PRIO_W      = 4;

  localparam int PRIO_BASE = 0;
  localparam int MASK_OFS  = DEF_PERIPHERALS;
  localparam int PEND_OFS  = DEF_PERIPHERALS + 1;

  // Register offsets for a non-default source count.
  function automatic int mask_ofs(input int n);
    return n;
  endfunction

  function automatic int pend_ofs(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/intr_rr_pick.sv
// Combinational winner select: highest priority, round-robin among equals
// starting just above the last granted index.
module intr_rr_pick import intr_pkg::*; #(
  parameter int PERIPHERALS = DEF_PERIPHERALS,
  parameter int PRIO_W      = DEF_PRIO_W,
  parameter int IDX_W       = $clog2(PERIPHERALS)
) (
  input  logic [PERIPHERALS-1:0]        eligible,
  input  logic [PERIPHERALS*PRIO_W-1:0] prio_flat,
  input  logic [IDX_W-1:0]              last_grant,
  output logic [IDX_W-1:0]              winner,
  output logic                          any
);

  logic [PRIO_W-1:0] prio_arr [PERIPHERALS];
  logic [PRIO_W-1:0] max_prio;
  logic [IDX_W-1:0]  idx;
  logic              found;

  for (genvar g = 0; g < PERIPHERALS; g++) begin : g_unpack
    assign prio_arr[g] = prio_flat[g*PRIO_W +: PRIO_W];
  end

  // Highest priority present among eligible sources.
  always_comb begin
    max_prio = '0;
    for (int i = 0; i < PERIPHERALS; i++) begin
      if (eligible[i] && (prio_arr[i] > max_prio)) begin
        max_prio = prio_arr[i];
      end else begin
        max_prio = max_prio;
      end
    end
  end

  // First eligible source at max priority, scanning upward from last_grant+1.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= PERIPHERALS; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % PERIPHERALS);
      if (!found && eligible[idx] && (prio_arr[idx] == max_prio)) begin
        winner = idx;
        found  = 1'b1;
      end else begin
        winner = winner;
        found  = found;
      end
    end
  end

  assign any = |eligible;

endmodule

// File: rtl/intr_prio_arbiter.sv
// Interrupt arbiter top: register file, sticky pending bits and the
// IDLE/ARB/GRANT handshake FSM.
module intr_prio_arbiter import intr_pkg::*; #(
  parameter int PERIPHERALS = DEF_PERIPHERALS,
  parameter int PRIO_W      = DEF_PRIO_W,
  parameter int IDX_W       = $clog2(PERIPHERALS),
  parameter int ADDR_W      = $clog2(PERIPHERALS) + 1,
  parameter int DATA_W      = PERIPHERALS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   w_r,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  output logic                   error,
  input  logic [PERIPHERALS-1:0] intr_active,
  output logic                   intr_valid,
  output logic [IDX_W-1:0]       intr_to_serv,
  input  logic                   intr_service
);

  localparam logic [ADDR_W-1:0]      PRIO_END  = ADDR_W'(PRIO_BASE + PERIPHERALS);
  localparam logic [ADDR_W-1:0]      MASK_ADDR = ADDR_W'(mask_ofs(PERIPHERALS));
  localparam logic [ADDR_W-1:0]      PEND_ADDR = ADDR_W'(pend_ofs(PERIPHERALS));
  localparam logic [IDX_W-1:0]       LAST_RST  = IDX_W'(PERIPHERALS - 1);
  localparam logic [PERIPHERALS-1:0] ONE_HOT0  = PERIPHERALS'(1);

  state_t                       state, state_nxt;
  logic [PRIO_W-1:0]            prio [PERIPHERALS];
  logic [PERIPHERALS*PRIO_W-1:0] prio_flat;
  logic [PERIPHERALS-1:0]       mask, pending, eligible, clr;
  logic [IDX_W-1:0]             last_grant, last_grant_nxt, serv_nxt, winner;
  logic                         valid_nxt, any;

  for (genvar g = 0; g < PERIPHERALS; g++) begin : g_flat
    assign prio_flat[g*PRIO_W +: PRIO_W] = prio[g];
  end

  assign eligible = pending & mask;

  intr_rr_pick #(
    .PERIPHERALS (PERIPHERALS),
    .PRIO_W      (PRIO_W),
    .IDX_W       (IDX_W)
  ) u_pick (
    .eligible   (eligible),
    .prio_flat  (prio_flat),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any)
  );

  // Register access port: one-cycle response to every enabled access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PERIPHERALS; i++) prio[i] <= '0;
      mask  <= '1;
      rdata <= '0;
      ready <= 1'b0;
      error <= 1'b0;
    end else begin
      ready <= enable;
      rdata <= '0;
      error <= 1'b0;
      if (enable) begin
        if (addr < PRIO_END) begin
          if (w_r) prio[addr[IDX_W-1:0]] <= wdata[PRIO_W-1:0];
          else     rdata <= DATA_W'(prio[addr[IDX_W-1:0]]);
        end else if (addr == MASK_ADDR) begin
          if (w_r) mask  <= wdata[PERIPHERALS-1:0];
          else     rdata <= DATA_W'(mask);
        end else if (addr == PEND_ADDR) begin
          if (w_r) error <= 1'b1;
          else     rdata <= DATA_W'(pending);
        end else begin
          error <= 1'b1;
        end
      end
    end
  end

  // Sticky pending; a line still held high re-pends in the clearing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr) | intr_active;
  end

  // Next-state and next-grant decode.
  always_comb begin
    state_nxt      = state;
    valid_nxt      = intr_valid;
    serv_nxt       = intr_to_serv;
    last_grant_nxt = last_grant;
    clr            = '0;
    case (state)
      IDLE: begin
        if (|eligible) state_nxt = ARB;
        else           state_nxt = IDLE;
      end
      ARB: begin
        if (any) begin
          state_nxt = GRANT;
          valid_nxt = 1'b1;
          serv_nxt  = winner;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (intr_service) begin
          state_nxt      = IDLE;
          valid_nxt      = 1'b0;
          serv_nxt       = '0;
          last_grant_nxt = intr_to_serv;
          clr            = ONE_HOT0 << intr_to_serv;
        end else begin
          state_nxt = GRANT;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        serv_nxt  = '0;
      end
    endcase
  end

  // FSM state and registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      intr_valid   <= 1'b0;
      intr_to_serv <= '0;
      last_grant   <= LAST_RST;
    end else begin
      state        <= state_nxt;
      intr_valid   <= valid_nxt;
      intr_to_serv <= serv_nxt;
      last_grant   <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_intr_prio_arbiter.sv
// Directed and randomized bench for intr_prio_arbiter with a transaction-level model.
module tb_intr_prio_arbiter;

  localparam int P = 16;

  logic        clk, rst, enable, w_r;
  logic [4:0]  addr;
  logic [15:0] wdata, rdata;
  logic        ready, error;
  logic [15:0] intr_active;
  logic        intr_valid;
  logic [3:0]  intr_to_serv;
  logic        intr_service;

  int checks = 0;
  int errors = 0;

  logic [3:0]  m_prio [P];
  logic [15:0] m_mask, m_pend;
  int          m_last;

  intr_prio_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .w_r          (w_r),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .error        (error),
    .intr_active  (intr_active),
    .intr_valid   (intr_valid),
    .intr_to_serv (intr_to_serv),
    .intr_service (intr_service)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input int a, input logic [15:0] d, input logic exp_err);
    enable = 1'b1; w_r = 1'b1; addr = 5'(a); wdata = d;
    step();
    chk("wr_ready", ready, 1'b1);
    chk("wr_error", error, exp_err);
    enable = 1'b0; w_r = 1'b0;
  endtask

  task automatic reg_read(input int a, output logic [15:0] rd, input logic exp_err);
    enable = 1'b1; w_r = 1'b0; addr = 5'(a);
    step();
    chk("rd_ready", ready, 1'b1);
    chk("rd_error", error, exp_err);
    rd = rdata;
    enable = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    intr_active = '0; intr_service = 1'b0; enable = 1'b0;
    #4;
    rst = 1'b0;
    step();
  endtask

  task automatic wait_grant(output int g);
    for (int i = 0; i < 12; i++) begin
      if (intr_valid) break;
      step();
    end
    chk("grant_seen", intr_valid, 1'b1);
    g = int'(intr_to_serv);
  endtask

  task automatic service();
    intr_service = 1'b1;
    step();
    chk("svc_drop", intr_valid, 1'b0);
    intr_service = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] v);
    intr_active = v;
    step();
    intr_active = '0;
  endtask

  // Winner = highest priority; ties go to the smallest forward distance from last grant.
  function automatic int model_pick();
    int best = -1, bestp = -1, bestd = P, d;
    for (int i = 0; i < P; i++) begin
      if (m_pend[i] && m_mask[i]) begin
        d = (i - m_last - 1 + P) % P;
        if (int'(m_prio[i]) > bestp || (int'(m_prio[i]) == bestp && d < bestd)) begin
          best = i; bestp = int'(m_prio[i]); bestd = d;
        end
      end
    end
    return best;
  endfunction

  initial begin
    int          g, e, a, guard;
    logic [15:0] rd, nm, pv;
    int          rr_exp [4] = '{2, 5, 7, 2};

    rst = 1'b1; enable = 1'b0; w_r = 1'b0; addr = '0; wdata = '0;
    intr_active = '0; intr_service = 1'b0;
    #23;
    rst = 1'b0;
    step();
    chk("rst_valid", intr_valid, 1'b0);
    chk("rst_serv", intr_to_serv, 4'd0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_rdata", rdata, 16'd0);

    // Async reset mid-grant with a read in flight
    pulse(16'h0040);
    wait_grant(g);
    chk("pre_rst_grant", g, 6);
    enable = 1'b1; w_r = 1'b0; addr = 5'd16;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", intr_valid, 1'b0);
    chk("async_serv", intr_to_serv, 4'd0);
    chk("async_ready", ready, 1'b0);
    chk("async_rdata", rdata, 16'd0);
    enable = 1'b0;
    #1;
    rst = 1'b0;
    step();
    reg_read(16, rd, 1'b0);
    chk("rst_mask", rd, 16'hFFFF);
    reg_read(17, rd, 1'b0);
    chk("rst_pend", rd, 16'h0000);

    // Priority win and service gap
    reg_write(3, 16'd5, 1'b0);
    reg_write(9, 16'd12, 1'b0);
    pulse(16'h0208);
    chk("lat_n", intr_valid, 1'b0);
    step();
    chk("lat_n1", intr_valid, 1'b0);
    step();
    chk("lat_n2_valid", intr_valid, 1'b1);
    chk("prio_win", intr_to_serv, 4'd9);
    intr_service = 1'b1;
    step();
    intr_service = 1'b0;
    chk("svc_m_valid", intr_valid, 1'b0);
    chk("svc_m_serv", intr_to_serv, 4'd0);
    step();
    chk("svc_m1_valid", intr_valid, 1'b0);
    step();
    chk("svc_m2_valid", intr_valid, 1'b1);
    chk("second_win", intr_to_serv, 4'd3);
    service();

    // Round-robin among equal priorities with held lines
    apply_reset();
    intr_active = 16'h00A4;
    for (int i = 0; i < 4; i++) begin
      wait_grant(g);
      chk("rr_grant", g, rr_exp[i]);
      service();
    end
    apply_reset();

    // Mask holds a pending source back until re-enabled
    reg_write(16, 16'hFFF7, 1'b0);
    pulse(16'h0008);
    repeat (4) step();
    chk("masked_no_grant", intr_valid, 1'b0);
    reg_read(17, rd, 1'b0);
    chk("masked_pend", rd, 16'h0008);
    reg_write(16, 16'hFFFF, 1'b0);
    chk("unmask_w", intr_valid, 1'b0);
    step();
    chk("unmask_w1", intr_valid, 1'b0);
    step();
    chk("unmask_w2", intr_valid, 1'b1);
    chk("unmask_idx", intr_to_serv, 4'd3);
    service();

    // Grant stays stable under config writes and a higher-priority arrival
    apply_reset();
    reg_write(4, 16'd3, 1'b0);
    pulse(16'h0010);
    wait_grant(g);
    chk("stab_first", g, 4);
    reg_write(4, 16'd0, 1'b0);
    reg_write(10, 16'd15, 1'b0);
    pulse(16'h0400);
    for (int i = 0; i < 4; i++) begin
      chk("stab_serv", {intr_valid, intr_to_serv}, 5'h14);
      step();
    end
    service();
    wait_grant(g);
    chk("stab_next", g, 10);
    service();

    // Error responses and read-only pending
    reg_write(16, 16'hFFFD, 1'b0);
    pulse(16'h0002);
    repeat (3) step();
    reg_write(17, 16'hFFFF, 1'b1);
    reg_read(17, rd, 1'b0);
    chk("pend_unchanged", rd, 16'h0002);
    reg_read(31, rd, 1'b1);
    chk("bad_addr_rdata", rd, 16'h0000);
    reg_write(5, 16'hFFFF, 1'b0);
    reg_read(5, rd, 1'b0);
    chk("prio_upper_zero", rd, 16'h000F);

    // Randomized traffic against the model
    apply_reset();
    for (int i = 0; i < P; i++) m_prio[i] = '0;
    m_mask = 16'hFFFF; m_pend = '0; m_last = P - 1;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) begin
        a  = $urandom_range(0, P - 1);
        nm = 16'($urandom);
        if ($urandom_range(0, 1) == 0) nm = nm & 16'h0003;
        reg_write(a, nm, 1'b0);
        m_prio[a] = nm[3:0];
      end
      nm = 16'($urandom) | 16'($urandom);
      pv = 16'($urandom);
      enable = 1'b1; w_r = 1'b1; addr = 5'd16; wdata = nm; intr_active = pv;
      step();
      chk("rand_mask_ready", ready, 1'b1);
      enable = 1'b0; w_r = 1'b0; intr_active = '0;
      m_mask = nm;
      m_pend = m_pend | pv;
      guard = 0;
      while (model_pick() >= 0 && guard < 20) begin
        e = model_pick();
        wait_grant(g);
        chk("rand_grant", g, e);
        service();
        m_pend[e] = 1'b0;
        m_last = e;
        guard++;
      end
      repeat (3) step();
      chk("rand_idle", intr_valid, 1'b0);
      reg_read(17, rd, 1'b0);
      chk("rand_pend", rd, m_pend);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
